// File: rtl/seg_scroll_mux.sv
// rtl/seg_scroll_mux.sv - scrolling multiplexed 7-segment display driver.
// Optional anti-ghosting blank cycle per digit slot: define SEG_SCROLL_BLANK_EN.
module seg_scroll_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 4,
  parameter int SCROLL_DIV  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pat_in,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic              freeze,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] dig_en
);

  localparam int IW = $clog2(DIGITS);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SCROLL_DIV);

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);

  typedef enum logic {
    S_COUNT = 1'b0,
    S_DUE   = 1'b1
  } scroll_state_t;

  scroll_state_t state, state_next;

  logic [SW-1:0] scroll_cnt;
  logic          scroll_due;
  logic          cnt_en;
  logic          xfer;

  logic [7:0]    window [DIGITS];

  logic [RW-1:0] ref_cnt;
  logic [IW-1:0] dig_idx;
  logic          blank;
  logic [7:0]    seg_next;
  logic [DIGITS-1:0] en_next;

  // Scroll pacing FSM: COUNT waits out SCROLL_DIV unfrozen clocks, DUE offers a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_COUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_COUNT: begin
        if (!freeze && (scroll_cnt == SCR_LAST)) begin
          state_next = S_DUE;
        end
      end
      S_DUE: begin
        if (xfer) begin
          state_next = S_COUNT;
        end
      end
      default: state_next = S_COUNT;
    endcase
  end

  // pat_ready depends only on the state register and freeze, never on pat_valid.
  always_comb begin
    scroll_due = (state == S_DUE);
    pat_ready  = scroll_due && !freeze;
    cnt_en     = !scroll_due && !freeze;
  end

  assign xfer = pat_valid && pat_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_cnt <= '0;
    end else if (xfer) begin
      scroll_cnt <= '0;
    end else if (cnt_en) begin
      if (scroll_cnt == SCR_LAST) begin
        scroll_cnt <= '0;
      end else begin
        scroll_cnt <= scroll_cnt + 1'b1;
      end
    end
  end

  // Window shifts left by one digit per accepted pattern; the oldest falls off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        window[k] <= '0;
      end
    end else if (xfer) begin
      for (int k = DIGITS - 1; k > 0; k--) begin
        window[k] <= window[k-1];
      end
      window[0] <= pat_in;
    end
  end

  // Scan timing runs regardless of freeze so the display never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      if (dig_idx == IDX_LAST) begin
        dig_idx <= '0;
      end else begin
        dig_idx <= dig_idx + 1'b1;
      end
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

`ifdef SEG_SCROLL_BLANK_EN
  assign blank = (ref_cnt == '0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = '0;
    en_next  = '0;
    if (!blank) begin
      seg_next = window[dig_idx];
      en_next  = DIGITS'(1) << dig_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      dig_en  <= '0;
    end else begin
      seg_out <= seg_next;
      dig_en  <= en_next;
    end
  end

endmodule
